// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed common-anode 7-segment driver with load snapshot
// Optional: define SEG7_BLANK_LEADING_ZEROS_EN to blank leading zero digits.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic [3:0] dp_mask,
    input  logic       load,
    input  logic       enable,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    logic [DIV_W-1:0] presc;
    logic [1:0]       idx;
    logic [3:0][3:0]  snap;
    logic [3:0]       dp_snap;
    logic             tick;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    logic [3:0]       blank;

    assign tick      = (presc == DIV_W'(REFRESH_DIV - 1));
    assign cur_digit = snap[idx];

    always_comb begin
        cur_seg = 7'b0111111;
        case (cur_digit)
            4'd0:    cur_seg = 7'b1000000;
            4'd1:    cur_seg = 7'b1111001;
            4'd2:    cur_seg = 7'b0100100;
            4'd3:    cur_seg = 7'b0110000;
            4'd4:    cur_seg = 7'b0011001;
            4'd5:    cur_seg = 7'b0010010;
            4'd6:    cur_seg = 7'b0000010;
            4'd7:    cur_seg = 7'b1111000;
            4'd8:    cur_seg = 7'b0000000;
            4'd9:    cur_seg = 7'b0010000;
            default: cur_seg = 7'b0111111;
        endcase
    end

`ifdef SEG7_BLANK_LEADING_ZEROS_EN
    logic zero3, zero2, zero1;
    assign zero3 = (snap[3] == 4'd0);
    assign zero2 = (snap[2] == 4'd0);
    assign zero1 = (snap[1] == 4'd0);

    // A decimal point on a digit keeps it and every digit to its right lit.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = zero3 & ~dp_snap[3];
        blank[2] = zero3 & zero2 & ~(|dp_snap[3:2]);
        blank[1] = zero3 & zero2 & zero1 & ~(|dp_snap[3:1]);
    end
`else
    assign blank = 4'b0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            idx        <= 2'd0;
            snap       <= '0;
            dp_snap    <= 4'b0000;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + DIV_W'(1);
            frame_done <= tick && (idx == 2'd3);
            if (tick) begin
                idx <= idx + 2'd1;
            end
            if (load) begin
                snap    <= {thousands, hundreds, tens, ones};
                dp_snap <= dp_mask;
            end
            // Outputs follow the current index/snapshot with one clock of latency.
            if (enable && !blank[idx]) begin
                an <= ~(4'b0001 << idx);
            end else begin
                an <= 4'b1111;
            end
            seg <= blank[idx] ? 7'b1111111 : cur_seg;
            dp  <= ~dp_snap[idx];
        end
    end

endmodule
